// File: rtl/id_ex_interlock_if.sv
// ID/EX handshake bundle: decoded ID fields in, registered EX fields out, plus stall/flush.
interface id_ex_interlock_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [4:0]      id_rs1_addr_i;
  logic [4:0]      id_rs2_addr_i;
  logic            id_rs1_use_i;
  logic            id_rs2_use_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [XLEN-1:0] id_imm_i;
  logic            id_opa_sel_i;
  logic            id_opb_sel_i;
  logic [3:0]      id_alu_op_i;
  logic [4:0]      id_rd_addr_i;
  logic            id_rd_wren_i;
  logic            flush_i;
  logic            id_stall_o;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_operand_a_o;
  logic [XLEN-1:0] ex_operand_b_o;
  logic [XLEN-1:0] ex_rs2_data_o;
  logic [3:0]      ex_alu_op_o;
  logic [4:0]      ex_rd_addr_o;
  logic            ex_rd_wren_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_opa_sel_i, id_opb_sel_i, id_alu_op_i,
           id_rd_addr_i, id_rd_wren_i, flush_i,
    input  id_stall_o, ex_valid_o, ex_pc_o, ex_operand_a_o, ex_operand_b_o, ex_rs2_data_o,
           ex_alu_op_o, ex_rd_addr_o, ex_rd_wren_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_opa_sel_i, id_opb_sel_i, id_alu_op_i,
           id_rd_addr_i, id_rd_wren_i, flush_i,
    output id_stall_o, ex_valid_o, ex_pc_o, ex_operand_a_o, ex_operand_b_o, ex_rs2_data_o,
           ex_alu_op_o, ex_rd_addr_o, ex_rd_wren_o
  );
endinterface

// File: rtl/id_ex_interlock.sv
// ID/EX pipeline register with destination scoreboard interlock for a non-forwarding pipeline.
// Define WB_WRITE_FIRST_EN when the register file writes in the first half-cycle (WB not checked).
module id_ex_interlock #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_DEPTH = 3
) (
  input logic              clk_i,
  input logic              rst_ni,
  id_ex_interlock_if.slave bus
);

`ifdef WB_WRITE_FIRST_EN
  localparam int unsigned NumChk = SB_DEPTH - 1;
`else
  localparam int unsigned NumChk = SB_DEPTH;
`endif

  // Slot 0 = EX, slot SB_DEPTH-1 = WB
  logic [SB_DEPTH-1:0]      sb_valid_q, sb_valid_d;
  logic [SB_DEPTH-1:0][4:0] sb_rd_q, sb_rd_d;

  logic            rs1_hit, rs2_hit, hazard, issue;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_opa_q, ex_opa_d;
  logic [XLEN-1:0] ex_opb_q, ex_opb_d;
  logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
  logic [3:0]      ex_alu_op_q, ex_alu_op_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_wren_q, ex_wren_d;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned i = 0; i < NumChk; i++) begin
      if (sb_valid_q[i] && (sb_rd_q[i] == bus.id_rs1_addr_i)) rs1_hit = 1'b1;
      if (sb_valid_q[i] && (sb_rd_q[i] == bus.id_rs2_addr_i)) rs2_hit = 1'b1;
    end
    hazard = bus.id_valid_i &
             ((bus.id_rs1_use_i & (bus.id_rs1_addr_i != 5'd0) & rs1_hit) |
              (bus.id_rs2_use_i & (bus.id_rs2_addr_i != 5'd0) & rs2_hit));
    issue  = bus.id_valid_i & ~hazard & ~bus.flush_i;
  end

  // Flush wins over hazard: the ID instruction is dropped, so there is nothing to hold.
  assign bus.id_stall_o = hazard & ~bus.flush_i;

  always_comb begin
    sb_valid_d[0] = issue & bus.id_rd_wren_i & (bus.id_rd_addr_i != 5'd0);
    sb_rd_d[0]    = sb_valid_d[0] ? bus.id_rd_addr_i : 5'd0;
    for (int unsigned i = 1; i < SB_DEPTH; i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_rd_d[i]    = sb_rd_q[i-1];
    end
  end

  always_comb begin
    ex_valid_d  = 1'b0;
    ex_pc_d     = '0;
    ex_opa_d    = '0;
    ex_opb_d    = '0;
    ex_rs2_d    = '0;
    ex_alu_op_d = '0;
    ex_rd_d     = '0;
    ex_wren_d   = 1'b0;
    if (issue) begin
      ex_valid_d  = 1'b1;
      ex_pc_d     = bus.id_pc_i;
      ex_opa_d    = bus.id_opa_sel_i ? bus.id_pc_i : bus.id_rs1_data_i;
      ex_opb_d    = bus.id_opb_sel_i ? bus.id_imm_i : bus.id_rs2_data_i;
      ex_rs2_d    = bus.id_rs2_data_i;
      ex_alu_op_d = bus.id_alu_op_i;
      ex_rd_d     = bus.id_rd_addr_i;
      ex_wren_d   = bus.id_rd_wren_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_valid_q  <= '0;
      sb_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_opa_q    <= '0;
      ex_opb_q    <= '0;
      ex_rs2_q    <= '0;
      ex_alu_op_q <= '0;
      ex_rd_q     <= '0;
      ex_wren_q   <= 1'b0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_rd_q     <= sb_rd_d;
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_opa_q    <= ex_opa_d;
      ex_opb_q    <= ex_opb_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_alu_op_q <= ex_alu_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_wren_q   <= ex_wren_d;
    end
  end

  assign bus.ex_valid_o     = ex_valid_q;
  assign bus.ex_pc_o        = ex_pc_q;
  assign bus.ex_operand_a_o = ex_opa_q;
  assign bus.ex_operand_b_o = ex_opb_q;
  assign bus.ex_rs2_data_o  = ex_rs2_q;
  assign bus.ex_alu_op_o    = ex_alu_op_q;
  assign bus.ex_rd_addr_o   = ex_rd_q;
  assign bus.ex_rd_wren_o   = ex_wren_q;

endmodule

// File: tb/tb_id_ex_interlock.sv
// Directed bench for id_ex_interlock: vector table plus stall, flush and reset sequences.
module tb_id_ex_interlock;

`ifdef WB_WRITE_FIRST_EN
  localparam int Wf = 1;
`else
  localparam int Wf = 0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  id_ex_interlock_if #(.XLEN(32)) bus ();

  id_ex_interlock #(.XLEN(32), .SB_DEPTH(3)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        use1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic        use2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        opa;
    logic        opb;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wren;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_rs2;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_wren;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t ins(logic valid, logic [31:0] pc, logic [4:0] rs1, logic use1,
                               logic [31:0] d1, logic [4:0] rs2, logic use2, logic [31:0] d2,
                               logic [31:0] imm, logic opa, logic opb, logic [3:0] op,
                               logic [4:0] rd, logic wren, logic flush);
    vec_t v;
    v.valid = valid; v.pc = pc; v.rs1 = rs1; v.use1 = use1; v.d1 = d1;
    v.rs2 = rs2; v.use2 = use2; v.d2 = d2; v.imm = imm; v.opa = opa; v.opb = opb;
    v.op = op; v.rd = rd; v.wren = wren; v.flush = flush;
    v.e_stall = 1'b0; v.e_valid = 1'b0; v.e_pc = '0; v.e_a = '0; v.e_b = '0;
    v.e_rs2 = '0; v.e_op = '0; v.e_rd = '0; v.e_wren = 1'b0;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vi, logic stall, logic valid, logic [31:0] pc,
                              logic [31:0] a, logic [31:0] b, logic [31:0] rs2,
                              logic [3:0] op, logic [4:0] rd, logic wren);
    vec_t v = vi;
    v.e_stall = stall; v.e_valid = valid; v.e_pc = pc; v.e_a = a; v.e_b = b;
    v.e_rs2 = rs2; v.e_op = op; v.e_rd = rd; v.e_wren = wren;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    bus.id_valid_i    = v.valid;
    bus.id_pc_i       = v.pc;
    bus.id_rs1_addr_i = v.rs1;
    bus.id_rs1_use_i  = v.use1;
    bus.id_rs1_data_i = v.d1;
    bus.id_rs2_addr_i = v.rs2;
    bus.id_rs2_use_i  = v.use2;
    bus.id_rs2_data_i = v.d2;
    bus.id_imm_i      = v.imm;
    bus.id_opa_sel_i  = v.opa;
    bus.id_opb_sel_i  = v.opb;
    bus.id_alu_op_i   = v.op;
    bus.id_rd_addr_i  = v.rd;
    bus.id_rd_wren_i  = v.wren;
    bus.flush_i       = v.flush;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive, check the combinational stall, clock once, check every EX field.
  task automatic apply(vec_t v, string tag);
    drive(v);
    #1;
    chk({tag, ".stall"}, 32'(bus.id_stall_o), 32'(v.e_stall));
    step();
    chk({tag, ".valid"}, 32'(bus.ex_valid_o), 32'(v.e_valid));
    chk({tag, ".pc"}, bus.ex_pc_o, v.e_pc);
    chk({tag, ".opa"}, bus.ex_operand_a_o, v.e_a);
    chk({tag, ".opb"}, bus.ex_operand_b_o, v.e_b);
    chk({tag, ".rs2"}, bus.ex_rs2_data_o, v.e_rs2);
    chk({tag, ".aluop"}, 32'(bus.ex_alu_op_o), 32'(v.e_op));
    chk({tag, ".rd"}, 32'(bus.ex_rd_addr_o), 32'(v.e_rd));
    chk({tag, ".wren"}, 32'(bus.ex_rd_wren_o), 32'(v.e_wren));
  endtask

  function automatic vec_t addi_x1();
    return ins(1, 'h300, 0, 1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 1, 0);
  endfunction
  function automatic vec_t nop();
    return ins(1, 'h304, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
  endfunction
  function automatic vec_t slt_dep();
    return ins(1, 'h310, 1, 1, 5, 3, 1, 7, 0, 0, 0, 2, 2, 1, 0);
  endfunction
  function automatic vec_t bubble();
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(bubble());
      step();
    end
  endtask

  // Producer to x1, gap nops, then dependent slt; count stall cycles under a bound.
  task automatic run_raw(int gap, int exp_stalls, string tag);
    int stalls = 0;
    drive(addi_x1());
    step();
    chk({tag, ".prod_rd"}, 32'(bus.ex_rd_addr_o), 32'd1);
    for (int i = 0; i < gap; i++) begin
      drive(nop());
      step();
    end
    drive(slt_dep());
    #1;
    while (bus.id_stall_o === 1'b1 && stalls < 10) begin
      step();
      stalls++;
      chk({tag, ".bub_valid"}, 32'(bus.ex_valid_o), 32'd0);
      chk({tag, ".bub_wren"}, 32'(bus.ex_rd_wren_o), 32'd0);
      #1;
    end
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    step();
    chk({tag, ".issue_valid"}, 32'(bus.ex_valid_o), 32'd1);
    chk({tag, ".issue_opa"}, bus.ex_operand_a_o, 32'd5);
    chk({tag, ".issue_rd"}, 32'(bus.ex_rd_addr_o), 32'd2);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;

    tbl[0] = ex(ins(1, 'h200, 6, 1, 'h11, 7, 1, 'h22, 0, 0, 0, 2, 5, 1, 0),
                0, 1, 'h200, 'h11, 'h22, 'h22, 2, 5, 1);
    tbl[1] = ex(ins(1, 'h204, 8, 1, 'h8000_0000, 9, 0, 1, 'hFFFF_FFFF, 0, 1, 0, 10, 1, 0),
                0, 1, 'h204, 'h8000_0000, 'hFFFF_FFFF, 1, 0, 10, 1);
    tbl[2] = ex(ins(1, 'h1000, 0, 0, 'hDEAD, 0, 0, 'hBEEF, 'h1234_5000, 1, 1, 0, 11, 1, 0),
                0, 1, 'h1000, 'h1000, 'h1234_5000, 'hBEEF, 0, 11, 1);
    // Not valid while x5 sits in WB: no stall, bubble
    tbl[3] = ex(ins(0, 'h1004, 5, 1, 3, 5, 1, 4, 9, 0, 0, 3, 12, 1, 0),
                0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = ex(ins(1, 'h1008, 0, 1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0),
                0, 1, 'h1008, 0, 7, 0, 0, 0, 1);
    tbl[5] = ex(ins(1, 'h100C, 0, 1, 'h55, 0, 1, 'h66, 0, 0, 0, 1, 13, 1, 0),
                0, 1, 'h100C, 'h55, 'h66, 'h66, 1, 13, 1);
    tbl[6] = ex(ins(1, 'h1010, 0, 1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 1, 0),
                0, 1, 'h1010, 0, 5, 0, 0, 1, 1);
    tbl[7] = ex(ins(1, 'h1014, 14, 1, 'hA, 1, 0, 'hB, 4, 0, 1, 0, 15, 1, 0),
                0, 1, 'h1014, 'hA, 4, 'hB, 0, 15, 1);
    tbl[8] = ex(ins(1, 'h1018, 0, 1, 1, 0, 0, 2, 3, 0, 0, 4, 20, 1, 1),
                0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flushed write to x20 must not be tracked
    tbl[9] = ex(ins(1, 'h2000, 20, 1, 9, 20, 1, 'hC, 0, 0, 0, 6, 21, 1, 0),
                0, 1, 'h2000, 9, 'hC, 'hC, 6, 21, 1);

    drive(bubble());
    #12;
    chk("reset.valid", 32'(bus.ex_valid_o), 32'd0);
    chk("reset.pc", bus.ex_pc_o, 32'd0);
    chk("reset.stall", 32'(bus.id_stall_o), 32'd0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));
    drain();

    run_raw(0, 3 - Wf, "raw_b2b");
    run_raw(1, 2 - Wf, "raw_d2");
    run_raw(3, 0, "raw_d4");

    // Flush coincident with a pending hazard
    drive(addi_x1());
    step();
    drive(slt_dep());
    bus.flush_i = 1'b1;
    #1;
    chk("flush.stall", 32'(bus.id_stall_o), 32'd0);
    step();
    chk("flush.valid", 32'(bus.ex_valid_o), 32'd0);
    chk("flush.wren", 32'(bus.ex_rd_wren_o), 32'd0);
    v = ins(1, 'h400, 2, 1, 'h77, 6, 1, 'h88, 0, 0, 0, 2, 5, 1, 0);
    drive(v);
    #1;
    chk("target.stall", 32'(bus.id_stall_o), 32'd0);
    step();
    chk("target.valid", 32'(bus.ex_valid_o), 32'd1);
    chk("target.opa", bus.ex_operand_a_o, 32'h77);
    drain();

    // Asynchronous reset while stalled
    drive(addi_x1());
    step();
    drive(slt_dep());
    #1;
    chk("rst_mid.stall_before", 32'(bus.id_stall_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid.valid", 32'(bus.ex_valid_o), 32'd0);
    chk("rst_mid.rd", 32'(bus.ex_rd_addr_o), 32'd0);
    chk("rst_mid.wren", 32'(bus.ex_rd_wren_o), 32'd0);
    chk("rst_mid.opb", bus.ex_operand_b_o, 32'd0);
    chk("rst_mid.stall", 32'(bus.id_stall_o), 32'd0);
    step();
    rst_ni = 1'b1;
    drive(ins(1, 'h500, 6, 1, 'h11, 7, 1, 'h22, 0, 0, 0, 2, 5, 1, 0));
    #1;
    chk("post_rst.stall", 32'(bus.id_stall_o), 32'd0);
    step();
    chk("post_rst.valid", 32'(bus.ex_valid_o), 32'd1);
    chk("post_rst.opa", bus.ex_operand_a_o, 32'h11);
    chk("post_rst.opb", bus.ex_operand_b_o, 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
